// File: rtl/mr_mini_mem_arbiter.sv
// rtl/mr_mini_mem_arbiter.sv - fetch/data memory arbiter with starvation guard; optional access timeout via MR_MINI_ARB_TIMEOUT_EN
module mr_mini_mem_arbiter #(
    parameter int STARVE_MAX = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [15:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_done_o,
    input  logic        da_req_i,
    input  logic        da_we_i,
    input  logic [15:0] da_addr_i,
    input  logic [15:0] da_wdata_i,
    output logic        da_gnt_o,
    output logic        da_done_o,
    output logic [15:0] rdata_o,
    output logic        mreq_o,
    output logic        mwe_o,
    output logic [15:0] maddr_o,
    output logic [15:0] mwdata_o,
    input  logic [15:0] mrdata_i,
    input  logic        mrdy_i,
    output logic        err_o
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam int            SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;     // 1 = data port owns the current transaction
    logic [SW-1:0] starve_q, starve_d;
    logic          if_gnt_q, if_gnt_d, da_gnt_q, da_gnt_d;
    logic          if_done_q, if_done_d, da_done_q, da_done_d;
    logic          mreq_q, mreq_d, mwe_q, mwe_d;
    logic [15:0]   maddr_q, maddr_d, mwdata_q, mwdata_d, rdata_q, rdata_d;
    logic          pick_if, finish;

`ifdef MR_MINI_ARB_TIMEOUT_EN
    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign if_gnt_o  = if_gnt_q;
    assign da_gnt_o  = da_gnt_q;
    assign if_done_o = if_done_q;
    assign da_done_o = da_done_q;
    assign mreq_o    = mreq_q;
    assign mwe_o     = mwe_q;
    assign maddr_o   = maddr_q;
    assign mwdata_o  = mwdata_q;
    assign rdata_o   = rdata_q;

    // State register and registered outputs; reset aborts any transaction silently
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            starve_q  <= '0;
            if_gnt_q  <= 1'b0;
            da_gnt_q  <= 1'b0;
            if_done_q <= 1'b0;
            da_done_q <= 1'b0;
            mreq_q    <= 1'b0;
            mwe_q     <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            rdata_q   <= '0;
`ifdef MR_MINI_ARB_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            if_gnt_q  <= if_gnt_d;
            da_gnt_q  <= da_gnt_d;
            if_done_q <= if_done_d;
            da_done_q <= da_done_d;
            mreq_q    <= mreq_d;
            mwe_q     <= mwe_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            rdata_q   <= rdata_d;
`ifdef MR_MINI_ARB_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    // Arbitration, access sequencing and next values of every registered output
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        mreq_d    = mreq_q;
        mwe_d     = mwe_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        rdata_d   = rdata_q;
        if_gnt_d  = 1'b0;
        da_gnt_d  = 1'b0;
        if_done_d = 1'b0;
        da_done_d = 1'b0;
        pick_if   = 1'b0;
        finish    = 1'b0;
`ifdef MR_MINI_ARB_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (if_req_i || da_req_i) begin
                    // Data wins ties until it has starved a waiting fetch STARVE_MAX times
                    pick_if = if_req_i && (!da_req_i || starve_q == STARVE_LIM);
                    state_d = S_ACCESS;
                    mreq_d  = 1'b1;
                    owner_d = !pick_if;
`ifdef MR_MINI_ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    if (pick_if) begin
                        if_gnt_d = 1'b1;
                        maddr_d  = if_addr_i;
                        mwe_d    = 1'b0;
                        mwdata_d = '0;
                        starve_d = '0;
                    end else begin
                        da_gnt_d = 1'b1;
                        maddr_d  = da_addr_i;
                        mwe_d    = da_we_i;
                        mwdata_d = da_wdata_i;
                        if (if_req_i && starve_q != STARVE_LIM) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (mrdy_i) begin
                    finish = 1'b1;
                    if (!mwe_q) begin
                        rdata_d = mrdata_i;
                    end
`ifdef MR_MINI_ARB_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
`endif
                end
                if (finish) begin
                    state_d   = S_DONE;
                    if_done_d = !owner_q;
                    da_done_d = owner_q;
                    mreq_d    = 1'b0;
                    mwe_d     = 1'b0;
                    maddr_d   = '0;
                    mwdata_d  = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
